count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit up-counter, with a programmable prescaler and a terminal value.
- Sits between a host or test-harness command port and the count datapath (the per-bit count bus feeding downstream modules).
- Runs one-shot or periodic count sequences and reports completion through a done/done_ack handshake.
- Exposes FSM state for observation.

Parameters:
- WIDTH, 16, count and terminal-value width.
- DIV_W, 8, prescaler divide field width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command can be accepted.
- cmd_op  input  2  0=START, 1=STOP, 2=RESUME, 3=CLEAR.
- cmd_term  input  WIDTH  terminal value; sampled on START only.
- cmd_div  input  DIV_W  prescale divisor; sampled on START only.
- periodic  input  1  sampled on START; 1=wrap and continue, 0=one-shot.
- done_ack  input  1  clears DONE.
- count  output  WIDTH  current count.
- tc  output  1  one-cycle pulse when count reaches terminal.
- done  output  1  high while in DONE.
- busy  output  1  high in RUN or PAUSE.
- state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it overrides everything, including cmd_valid.
- Reset values: state=IDLE, count=0, tc=0, done=0, busy=0, cmd_ready=1. Internal term, div, presc and mode all 0.
- Handshake: a command is accepted on a rising edge where cmd_valid&&cmd_ready. cmd_ready=0 only in DONE; everywhere else it is 1. A command held across cycles is accepted once per accepting edge.
- Prescaler: presc advances only in RUN with no accepted command that cycle. tick = (presc==div). On tick presc<=0, otherwise presc<=presc+1.
- Counting: on tick, if count==term it is a terminal event; otherwise count<=count+1.
- Terminal event, one-shot: count holds term, tc=1 for one cycle, next state DONE.
- Terminal event, periodic: count<=0, tc=1, state stays RUN.
- term=0: every tick is a terminal event.
- count never exceeds term after START. No arithmetic overflow is possible; compare is unsigned, full WIDTH.
- Latency: first increment lands D+1 edges after the START accept edge (D=cmd_div). With div=0 the counter increments every cycle.
- IDLE:
  - START -> RUN; count<=0, presc<=0; term, div and mode loaded.
  - CLEAR -> count<=0.
  - STOP and RESUME ignored (accepted, no effect).
- RUN:
  - STOP -> PAUSE; count and presc held.
  - START -> restart as from IDLE.
  - CLEAR -> count<=0, presc<=0, stay RUN.
  - RESUME ignored.
- PAUSE:
  - RESUME -> RUN; presc continues from its held value.
  - START -> restart.
  - CLEAR -> count<=0, presc<=0, stay PAUSE.
  - STOP ignored.
- DONE:
  - done=1; commands blocked.
  - done_ack sampled high -> IDLE next edge; count retains term.
  - done_ack while not in DONE is ignored.
- Simultaneous command and tick: the accepted command wins. No increment and no tc that cycle; STOP in the tick cycle leaves count unchanged.
- tc is registered; it asserts in the cycle after the edge on which the terminal event is decided.
- Reset mid-RUN, PAUSE or DONE: all reset values apply at the next edge; no tc or done glitch.

Test Plan:
- Reset then START term=5, div=0, one-shot:
  - count steps 1..5 on consecutive edges.
  - tc pulses once; state=3, done=1, cmd_ready=0.
  - done_ack -> state=0, count=5.
- START term=3, div=2, periodic:
  - count advances every 3 cycles: 0,1,2,3, then wraps to 0.
  - tc pulse every 12 cycles.
  - busy=1 throughout.
- RUN term=10, div=0:
  - STOP at count=4 -> count holds 4 for 20 cycles, state=2.
  - RESUME -> reaches 10 six edges later.
- CLEAR issued on the same cycle as a tick, at count=7 in RUN -> count=0 and presc=0 at the next edge, no tc, state stays 1.
- START with cmd_valid held in DONE -> not accepted until done_ack. After IDLE it is accepted once and counting restarts at 0.
- rst asserted in RUN at count=9, with cmd_valid=1 and op=START -> all outputs at reset values at the next edge; no START taken.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: command-driven sequencer for a prescaled up-counter with a
// terminal value. It runs one-shot or periodic sequences and reports
// completion through a done/done_ack handshake.
module count_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_term,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             periodic,
    input  logic             done_ack,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   term_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   presc_q;
    logic               mode_q;

    logic               accept_c;
    logic               start_c;
    logic               tick_c;

    // Command acceptance and prescaler terminal decode.
    always_comb begin
        accept_c = cmd_valid && cmd_ready;
        start_c  = accept_c && (cmd_op == OP_START);
        tick_c   = (presc_q == div_q);
    end

    assign state = state_q;

    // Sequencer: state, counter, prescaler and registered status outputs.
    // An accepted command always takes priority over a prescaler tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count     <= '0;
            term_q    <= '0;
            div_q     <= '0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            tc        <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            tc <= 1'b0;
            if (start_c) begin
                // START restarts from any non-DONE state.
                state_q   <= ST_RUN;
                count     <= '0;
                presc_q   <= '0;
                term_q    <= cmd_term;
                div_q     <= cmd_div;
                mode_q    <= periodic;
                busy      <= 1'b1;
                done      <= 1'b0;
                cmd_ready <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept_c && (cmd_op == OP_CLEAR)) begin
                            count <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (accept_c) begin
                            if (cmd_op == OP_STOP) begin
                                state_q <= ST_PAUSE;
                            end else if (cmd_op == OP_CLEAR) begin
                                count   <= '0;
                                presc_q <= '0;
                            end
                        end else if (tick_c) begin
                            presc_q <= '0;
                            if (count == term_q) begin
                                tc <= 1'b1;
                                if (mode_q) begin
                                    count <= '0;
                                end else begin
                                    state_q   <= ST_DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    cmd_ready <= 1'b0;
                                end
                            end else begin
                                count <= count + WIDTH'(1);
                            end
                        end else begin
                            presc_q <= presc_q + DIV_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (accept_c) begin
                            if (cmd_op == OP_RESUME) begin
                                state_q <= ST_RUN;
                            end else if (cmd_op == OP_CLEAR) begin
                                count   <= '0;
                                presc_q <= '0;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (done_ack) begin
                            state_q   <= ST_IDLE;
                            done      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: a vector table for the basic one-shot
// flow plus directed sequences for periodic, pause/resume, clear, DONE
// blocking and reset corner cases.
module tb_count_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIV_W = 8;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_term;
    logic [DIV_W-1:0] cmd_div;
    logic             periodic;
    logic             done_ack;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    int n_cmp  = 0;
    int n_fail = 0;

    count_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_term  (cmd_term),
        .cmd_div   (cmd_div),
        .periodic  (periodic),
        .done_ack  (done_ack),
        .count     (count),
        .tc        (tc),
        .done      (done),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             valid;
        logic [1:0]       op;
        logic [WIDTH-1:0] term;
        logic [DIV_W-1:0] div;
        logic             per;
        logic             ack;
        logic [WIDTH-1:0] e_count;
        logic             e_tc;
        logic             e_done;
        logic             e_busy;
        logic [1:0]       e_state;
        logic             e_ready;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_count, input int e_tc,
                           input int e_done, input int e_busy, input int e_state,
                           input int e_ready);
        chk({tag, ".count"}, int'(count), e_count);
        chk({tag, ".tc"}, int'(tc), e_tc);
        chk({tag, ".done"}, int'(done), e_done);
        chk({tag, ".busy"}, int'(busy), e_busy);
        chk({tag, ".state"}, int'(state), e_state);
        chk({tag, ".ready"}, int'(cmd_ready), e_ready);
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] term, input logic [DIV_W-1:0] dv,
                         input logic per, input logic ack);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_term  = term;
        cmd_div   = dv;
        periodic  = per;
        done_ack  = ack;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, OP_STOP, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, OP_STOP, '0, '0, 1'b0, 1'b0);

        //        rst  vld  op         term    div   per  ack   count tc done busy st ready
        vt[0]  = '{1'b1, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[1]  = '{1'b0, 1'b1, OP_START,  16'd5, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[2]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[4]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[5]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[6]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0};
        vt[8]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
        vt[9]  = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[10] = '{1'b0, 1'b0, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[11] = '{1'b0, 1'b1, OP_CLEAR,  16'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vt[12] = '{1'b0, 1'b1, OP_STOP,   16'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};

        // One-shot flow and IDLE commands from the table.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst, vt[i].valid, vt[i].op, vt[i].term, vt[i].div,
                  vt[i].per, vt[i].ack);
            step();
            chk_all($sformatf("vec%0d", i), int'(vt[i].e_count), int'(vt[i].e_tc),
                    int'(vt[i].e_done), int'(vt[i].e_busy), int'(vt[i].e_state),
                    int'(vt[i].e_ready));
        end
        idle();
        step();

        // Periodic, term=3, div=2: advance every 3 edges, wrap and tc every 12.
        drive(1'b0, 1'b1, OP_START, 16'd3, 8'd2, 1'b1, 1'b0);
        step();
        chk_all("per.start", 0, 0, 0, 1, 1, 1);
        idle();
        for (int k = 1; k <= 26; k++) begin
            step();
            chk_all($sformatf("per.k%0d", k), (k / 3) % 4, (k % 12 == 0) ? 1 : 0,
                    0, 1, 1, 1);
        end

        // Pause/resume, term=10, div=0.
        drive(1'b0, 1'b1, OP_START, 16'd10, 8'd0, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("pr.run%0d", k), int'(count), k);
        end
        drive(1'b0, 1'b1, OP_STOP, '0, '0, 1'b0, 1'b0);
        step();
        chk_all("pr.stop", 4, 0, 0, 1, 2, 1);
        idle();
        for (int j = 0; j < 20; j++) begin
            done_ack = (j == 5);
            step();
            chk_all($sformatf("pr.hold%0d", j), 4, 0, 0, 1, 2, 1);
        end
        drive(1'b0, 1'b1, OP_RESUME, '0, '0, 1'b0, 1'b0);
        step();
        chk_all("pr.resume", 4, 0, 0, 1, 1, 1);
        idle();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_all($sformatf("pr.after%0d", k), 4 + k, 0, 0, 1, 1, 1);
        end
        step();
        chk_all("pr.term", 10, 1, 1, 0, 3, 0);
        done_ack = 1'b1;
        step();
        chk_all("pr.ack", 10, 0, 0, 0, 0, 1);
        idle();

        // CLEAR coinciding with a tick at count=7, term=10, div=2.
        drive(1'b0, 1'b1, OP_START, 16'd10, 8'd2, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 23; k++) step();
        chk("clr.pre", int'(count), 7);
        drive(1'b0, 1'b1, OP_CLEAR, '0, '0, 1'b0, 1'b0);
        step();
        chk_all("clr.edge", 0, 0, 0, 1, 1, 1);
        idle();
        step();
        chk("clr.p1", int'(count), 0);
        step();
        chk("clr.p2", int'(count), 0);
        step();
        chk("clr.p3", int'(count), 1);

        // START held during DONE is blocked until done_ack, then taken once.
        drive(1'b0, 1'b1, OP_START, 16'd1, 8'd0, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk("blk.c1", int'(count), 1);
        step();
        chk_all("blk.done", 1, 1, 1, 0, 3, 0);
        drive(1'b0, 1'b1, OP_START, 16'd2, 8'd0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step();
            chk_all($sformatf("blk.hold%0d", j), 1, 0, 1, 0, 3, 0);
        end
        done_ack = 1'b1;
        step();
        chk_all("blk.ack", 1, 0, 0, 0, 0, 1);
        done_ack = 1'b0;
        step();
        chk_all("blk.acc", 0, 0, 0, 1, 1, 1);
        idle();
        step();
        chk("blk.n1", int'(count), 1);
        step();
        chk("blk.n2", int'(count), 2);
        step();
        chk_all("blk.end", 2, 1, 1, 0, 3, 0);
        done_ack = 1'b1;
        step();
        idle();

        // Reset in RUN at count=9 with START offered.
        drive(1'b0, 1'b1, OP_START, 16'd20, 8'd0, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 9; k++) step();
        chk("rst.pre", int'(count), 9);
        drive(1'b1, 1'b1, OP_START, 16'd20, 8'd0, 1'b0, 1'b0);
        step();
        chk_all("rst.edge", 0, 0, 0, 0, 0, 1);
        idle();
        step();
        chk_all("rst.after", 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
